// File: rtl/ram_hs_be.sv
// Byte-addressed big-endian RAM behind a mov/moc handshake, with a programmable wait-state count.
// Optional macro RAM_ALIGN_CHECK_EN rejects misaligned halfword and word accesses.
module ram_hs_be #(
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mov,
  input  logic                  rw,
  input  logic [1:0]            typeData,
  input  logic                  signExt,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  moc,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  next_s;
  logic [3:0]              cnt_r;
  logic                    rw_r;
  logic [1:0]              type_r;
  logic                    sext_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [31:0]             din_r;
  logic                    moc_r;
  logic                    err_r;
  logic [31:0]             dout_r;
  logic [7:0]              mem [DEPTH];

  logic                    op_rw_s;
  logic [1:0]              op_type_s;
  logic                    op_sext_s;
  logic [ADDR_WIDTH-1:0]   op_addr_s;
  logic [31:0]             op_din_s;
  logic [2:0]              size_m1_s;
  logic [ADDR_WIDTH:0]     last_s;
  logic                    align_err_s;
  logic                    err_s;
  logic                    capture_s;
  logic                    access_s;
  logic                    ext_s;
  logic [AW-1:0]           base_s;
  logic [7:0]              rb0_s;
  logic [7:0]              rb1_s;
  logic [7:0]              rb2_s;
  logic [7:0]              rb3_s;
  logic [31:0]             rdata_s;

  // Operand source: live inputs while idle (needed when there are no wait states), captured copy afterwards
  always_comb begin
    op_rw_s   = rw_r;
    op_type_s = type_r;
    op_sext_s = sext_r;
    op_addr_s = addr_r;
    op_din_s  = din_r;
    if (state_r == IDLE) begin
      op_rw_s   = rw;
      op_type_s = typeData;
      op_sext_s = signExt;
      op_addr_s = address;
      op_din_s  = DataIn;
    end else begin
      op_rw_s   = rw_r;
      op_type_s = type_r;
      op_sext_s = sext_r;
      op_addr_s = addr_r;
      op_din_s  = din_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (mov && !moc_r) begin
          if (WAIT_STATES > 0) begin
            next_s = WAIT;
          end else begin
            next_s = DONE;
          end
        end else begin
          next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          next_s = DONE;
        end else begin
          next_s = WAIT;
        end
      end
      DONE: begin
        if (!mov) begin
          next_s = IDLE;
        end else begin
          next_s = DONE;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  assign capture_s = (state_r == IDLE) && mov && !moc_r;
  assign access_s  = (next_s == DONE) && (state_r != DONE);

  // Error detection; the extra top bit of last_s keeps the range check free of wrap-around
  always_comb begin
    size_m1_s   = 3'd0;
    align_err_s = 1'b0;
    case (op_type_s)
      2'b00:   size_m1_s = 3'd0;
      2'b01:   size_m1_s = 3'd1;
      2'b10:   size_m1_s = 3'd3;
      default: size_m1_s = 3'd0;
    endcase
`ifdef RAM_ALIGN_CHECK_EN
    if ((op_type_s == 2'b01) && op_addr_s[0]) begin
      align_err_s = 1'b1;
    end else if ((op_type_s == 2'b10) && (op_addr_s[1:0] != 2'b00)) begin
      align_err_s = 1'b1;
    end else begin
      align_err_s = 1'b0;
    end
`else
    align_err_s = 1'b0;
`endif
    last_s = {1'b0, op_addr_s} + {{(ADDR_WIDTH-2){1'b0}}, size_m1_s};
    err_s  = (last_s >= (ADDR_WIDTH+1)'(DEPTH)) || (op_type_s == 2'b11) || align_err_s;
  end

  assign base_s = op_addr_s[AW-1:0];
  assign rb0_s  = mem[base_s];
  assign rb1_s  = mem[base_s + AW'(3'd1)];
  assign rb2_s  = mem[base_s + AW'(3'd2)];
  assign rb3_s  = mem[base_s + AW'(3'd3)];

  // Right-aligned read data with optional sign extension from the loaded MSB
  always_comb begin
    ext_s   = 1'b0;
    rdata_s = 32'd0;
    case (op_type_s)
      2'b00: begin
        ext_s   = op_sext_s & rb0_s[7];
        rdata_s = {{24{ext_s}}, rb0_s};
      end
      2'b01: begin
        ext_s   = op_sext_s & rb0_s[7];
        rdata_s = {{16{ext_s}}, rb0_s, rb1_s};
      end
      2'b10:   rdata_s = {rb0_s, rb1_s, rb2_s, rb3_s};
      default: rdata_s = 32'd0;
    endcase
  end

  // Control, capture and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      moc_r   <= 1'b0;
      err_r   <= 1'b0;
      dout_r  <= 32'd0;
      rw_r    <= 1'b0;
      type_r  <= 2'b00;
      sext_r  <= 1'b0;
      addr_r  <= '0;
      din_r   <= 32'd0;
    end else begin
      state_r <= next_s;
      moc_r   <= (next_s == DONE);
      if (capture_s) begin
        rw_r   <= rw;
        type_r <= typeData;
        sext_r <= signExt;
        addr_r <= address;
        din_r  <= DataIn;
        cnt_r  <= 4'(WAIT_STATES);
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (access_s) begin
        err_r <= err_s;
        if (err_s) begin
          dout_r <= 32'd0;
        end else if (op_rw_s) begin
          dout_r <= rdata_s;
        end else begin
          dout_r <= dout_r;
        end
      end else begin
        err_r  <= err_r;
        dout_r <= dout_r;
      end
    end
  end

  // Storage write port; deliberately unreset so contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && access_s && !op_rw_s && !err_s) begin
      case (op_type_s)
        2'b00: mem[base_s] <= op_din_s[7:0];
        2'b01: begin
          mem[base_s]              <= op_din_s[15:8];
          mem[base_s + AW'(3'd1)]  <= op_din_s[7:0];
        end
        2'b10: begin
          mem[base_s]              <= op_din_s[31:24];
          mem[base_s + AW'(3'd1)]  <= op_din_s[23:16];
          mem[base_s + AW'(3'd2)]  <= op_din_s[15:8];
          mem[base_s + AW'(3'd3)]  <= op_din_s[7:0];
        end
        default: ;
      endcase
    end
  end

  assign DataOut = dout_r;
  assign moc     = moc_r;
  assign err     = err_r;

endmodule

// File: tb/tb_ram_hs_be.sv
// Directed bench for ram_hs_be (DEPTH=256, WAIT_STATES=2) with a transaction-level reference model.
module tb_ram_hs_be;

  logic        clk = 1'b0;
  logic        reset;
  logic        mov;
  logic        rw;
  logic [1:0]  typeData;
  logic        signExt;
  logic [31:0] address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        moc;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  logic        exp_moc  = 1'b0;
  logic        exp_err  = 1'b0;
  logic [31:0] exp_dout = 32'd0;
  logic        obs_err;
  logic [31:0] obs_dout;
  logic [7:0]  mm [256];

  ram_hs_be #(.DEPTH(256), .ADDR_WIDTH(32), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .typeData(typeData),
    .signExt(signExt), .address(address), .DataIn(DataIn),
    .DataOut(DataOut), .moc(moc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: big-endian byte array, size/range/type rules applied arithmetically
  task automatic model_access(input logic r, input logic [1:0] t, input logic se,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic e, output logic [31:0] v);
    int sz;
    sz = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    e  = (t == 2'd3) || ((longint'({32'd0, a}) + longint'(sz)) > 64'd256);
`ifdef RAM_ALIGN_CHECK_EN
    if ((t == 2'd1 && a[0]) || (t == 2'd2 && a[1:0] != 2'd0)) e = 1'b1;
`endif
    v = 32'd0;
    if (!e) begin
      if (r) begin
        for (int i = 0; i < sz; i++) v = (v << 8) | {24'd0, mm[int'(a) + i]};
        if (se && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
      end else begin
        for (int i = 0; i < sz; i++) mm[int'(a) + i] = 8'(d >> (8*(sz-1-i)));
      end
    end
  endtask

  // Cycle-by-cycle comparison against the model expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("moc", {31'd0, moc}, {31'd0, exp_moc});
      check("dataout", DataOut, exp_dout);
      if (exp_moc) check("err", {31'd0, err}, {31'd0, exp_err});
    end
  end

  // One handshake: capture, 2 wait cycles, DONE held for 'hold' cycles, then release
  task automatic do_op(input logic r, input logic [1:0] t, input logic se,
                       input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit drop_early, input bit rst_wait);
    logic        e;
    logic [31:0] v;
    rw = r; typeData = t; signExt = se; address = a; DataIn = d; mov = 1'b1;
    @(posedge clk); #1;
    rw = ~r; typeData = ~t; signExt = ~se; address = a ^ 32'h5; DataIn = ~d;
    if (drop_early) mov = 1'b0;
    if (rst_wait) begin
      reset = 1'b1; mov = 1'b0;
      @(posedge clk); #1;
      exp_moc = 1'b0; exp_dout = 32'd0;
      reset = 1'b0;
    end else begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_access(r, t, se, a, d, e, v);
      exp_moc = 1'b1;
      exp_err = e;
      if (e) exp_dout = 32'd0;
      else if (r) exp_dout = v;
      obs_err = err; obs_dout = DataOut;
      for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
      mov = 1'b0;
      @(posedge clk); #1;
      exp_moc = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; mov = 1'b0; rw = 1'b0; typeData = 2'd0; signExt = 1'b0;
    address = 32'd0; DataIn = 32'd0;
    for (int i = 0; i < 256; i++) mm[i] = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_moc", {31'd0, moc}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dout", DataOut, 32'd0);

    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'hA1B2C3D4, 0, 1'b0, 1'b0);
    check("wr_word_err", {31'd0, obs_err}, 32'd0);
    check("wr_word_dout", obs_dout, 32'd0);
    do_op(1'b1, 2'd0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0);
    check("rd_b10", obs_dout, 32'h000000A1);
    do_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h0, 0, 1'b0, 1'b0);
    check("rd_b13", obs_dout, 32'h000000D4);
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0);
    check("rd_w10", obs_dout, 32'hA1B2C3D4);

    do_op(1'b0, 2'd1, 1'b0, 32'h20, 32'h00008001, 0, 1'b0, 1'b0);
    do_op(1'b1, 2'd1, 1'b1, 32'h20, 32'h0, 0, 1'b0, 1'b0);
    check("rd_h_sext", obs_dout, 32'hFFFF8001);
    do_op(1'b1, 2'd1, 1'b0, 32'h20, 32'h0, 0, 1'b0, 1'b0);
    check("rd_h_zext", obs_dout, 32'h00008001);
    do_op(1'b0, 2'd0, 1'b0, 32'h30, 32'h00000080, 0, 1'b0, 1'b0);
    do_op(1'b1, 2'd0, 1'b1, 32'h30, 32'h0, 0, 1'b0, 1'b0);
    check("rd_b_sext", obs_dout, 32'hFFFFFF80);

    do_op(1'b0, 2'd0, 1'b0, 32'hFE, 32'h00000077, 0, 1'b0, 1'b0);
    do_op(1'b0, 2'd0, 1'b0, 32'hFF, 32'h00000088, 0, 1'b0, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 32'hFE, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    check("wr_fe_err", {31'd0, obs_err}, 32'd1);
    check("wr_fe_dout", obs_dout, 32'd0);
    do_op(1'b1, 2'd0, 1'b0, 32'hFE, 32'h0, 0, 1'b0, 1'b0);
    check("keep_fe", obs_dout, 32'h00000077);
    do_op(1'b1, 2'd0, 1'b0, 32'hFF, 32'h0, 0, 1'b0, 1'b0);
    check("keep_ff", obs_dout, 32'h00000088);
    do_op(1'b0, 2'd2, 1'b0, 32'hFC, 32'h01020304, 0, 1'b0, 1'b0);
    check("wr_fc_err", {31'd0, obs_err}, 32'd0);
    do_op(1'b1, 2'd2, 1'b0, 32'hFC, 32'h0, 0, 1'b0, 1'b0);
    check("rd_fc", obs_dout, 32'h01020304);
    do_op(1'b1, 2'd0, 1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0);
    check("rd_100_err", {31'd0, obs_err}, 32'd1);
    do_op(1'b1, 2'd3, 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b0);
    check("type11_err", {31'd0, obs_err}, 32'd1);
    check("type11_dout", obs_dout, 32'd0);

    do_op(1'b0, 2'd2, 1'b0, 32'h11, 32'h55667788, 0, 1'b0, 1'b0);
    do_op(1'b1, 2'd2, 1'b0, 32'h11, 32'h0, 0, 1'b0, 1'b0);
`ifdef RAM_ALIGN_CHECK_EN
    check("mis_w11_err", {31'd0, obs_err}, 32'd1);
    check("mis_w11_dout", obs_dout, 32'd0);
`else
    check("mis_w11_err", {31'd0, obs_err}, 32'd0);
    check("mis_w11_dout", obs_dout, 32'h55667788);
`endif

    do_op(1'b1, 2'd0, 1'b0, 32'h10, 32'h0, 5, 1'b0, 1'b0);
    do_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h0, 0, 1'b0, 1'b0);
    do_op(1'b1, 2'd1, 1'b1, 32'h20, 32'h0, 0, 1'b1, 1'b0);
    check("drop_early", obs_dout, 32'hFFFF8001);

    do_op(1'b0, 2'd0, 1'b0, 32'h40, 32'h00000011, 0, 1'b0, 1'b0);
    do_op(1'b0, 2'd0, 1'b0, 32'h40, 32'h00000055, 0, 1'b0, 1'b1);
    check("rst_wait_moc", {31'd0, moc}, 32'd0);
    do_op(1'b1, 2'd0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0);
    check("rst_wait_keep", obs_dout, 32'h00000011);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
